interconnect_top: RTL and testbench

- Top level of a minimal on-chip interconnect: a master FSM accepts burst write/read commands from the top-level pins and drives an internal request bus to a slave FSM.
- The slave FSM owns a 16 x 32-bit register memory.
- Bursts are 1–15 beats to incrementing, wrapping addresses.
- The block is the self-contained bring-up vehicle for the master/slave handshake.

---
 rtl/interconnect_pkg.sv | 20 ++
 rtl/interconnect_if.sv | 24 ++
 rtl/bus_master.sv | 66 ++++++
 rtl/bus_slave.sv | 47 ++++
 rtl/interconnect_top.sv | 32 +++
 tb/tb_interconnect_top.sv | 161 ++++++++++++++++
 6 files changed

// File: rtl/interconnect_pkg.sv
// Shared widths, FSM state encodings and the master-to-slave request word
// for the minimal burst interconnect.
package interconnect_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {M_IDLE, M_WRITE, M_READ} mst_state_e;
    typedef enum logic {S_IDLE, S_SERVE} slv_state_e;

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/interconnect_if.sv
// Top-level command/data pins of the interconnect, grouped for the host
// (master modport) and the interconnect itself (slave modport).
interface interconnect_if;
    import interconnect_pkg::*;

    logic              io_start;
    logic              io_top_wr;
    logic              io_top_rd;
    logic [ADDR_W-1:0] io_top_address;
    logic [LEN_W-1:0]  io_top_length;
    logic [DATA_W-1:0] io_top_wdata;
    logic [DATA_W-1:0] io_top_rdata;

    modport master (
        output io_start, io_top_wr, io_top_rd, io_top_address, io_top_length, io_top_wdata,
        input  io_top_rdata
    );

    modport slave (
        input  io_start, io_top_wr, io_top_rd, io_top_address, io_top_length, io_top_wdata,
        output io_top_rdata
    );

endinterface

// File: rtl/bus_master.sv
// Command FSM: accepts a burst in IDLE and issues one registered request per
// cycle to incrementing, wrapping addresses until the beat count is reached.
module bus_master
    import interconnect_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] address,
    input  logic [LEN_W-1:0]  length,
    input  logic [DATA_W-1:0] wdata,
    output req_t              req
);

    mst_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    req_t              req_q;

    logic [LEN_W-1:0]  cnt_nxt;
    logic [ADDR_W-1:0] beat_addr;

    assign cnt_nxt   = cnt_q + LEN_W'(1);
    // Address width truncation gives the modulo-DEPTH wrap for free.
    assign beat_addr = addr_q + ADDR_W'(cnt_nxt);
    assign req       = req_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= M_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            unique case (state_q)
                M_IDLE: begin
                    if (start && (wr || rd) && (length != '0)) begin
                        addr_q  <= address;
                        len_q   <= length;
                        cnt_q   <= '0;
                        req_q   <= '{valid: 1'b1, wr: wr, addr: address,
                                     wdata: wr ? wdata : '0};
                        state_q <= wr ? M_WRITE : M_READ;
                    end
                end
                M_WRITE, M_READ: begin
                    if (cnt_nxt == len_q) begin
                        cnt_q       <= '0;
                        req_q.valid <= 1'b0;
                        state_q     <= M_IDLE;
                    end else begin
                        cnt_q <= cnt_nxt;
                        req_q <= '{valid: 1'b1, wr: (state_q == M_WRITE), addr: beat_addr,
                                   wdata: (state_q == M_WRITE) ? wdata : '0};
                    end
                end
                default: state_q <= M_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/bus_slave.sv
// Zero-wait-state slave: serves each valid request at the next edge against a
// 16-word register memory; reads land in a registered data output.
module bus_slave
    import interconnect_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  req_t              req,
    output logic [DATA_W-1:0] rdata
);

    slv_state_e        state_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    assign rdata = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rdata_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req.valid) begin
                        state_q <= S_SERVE;
                        if (req.wr) mem_q[req.addr] <= req.wdata;
                        else        rdata_q         <= mem_q[req.addr];
                    end
                end
                S_SERVE: begin
                    if (req.valid) begin
                        if (req.wr) mem_q[req.addr] <= req.wdata;
                        else        rdata_q         <= mem_q[req.addr];
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/interconnect_top.sv
// Burst interconnect bring-up top: wires the command master to the memory
// slave over the internal request bus.
module interconnect_top
    import interconnect_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    interconnect_if.slave bus
);

    req_t req;

    bus_master u_master (
        .clk     (clock),
        .rst_n   (reset),
        .start   (bus.io_start),
        .wr      (bus.io_top_wr),
        .rd      (bus.io_top_rd),
        .address (bus.io_top_address),
        .length  (bus.io_top_length),
        .wdata   (bus.io_top_wdata),
        .req     (req)
    );

    bus_slave u_slave (
        .clk   (clock),
        .rst_n (reset),
        .req   (req),
        .rdata (bus.io_top_rdata)
    );

endmodule

// File: tb/tb_interconnect_top.sv
// Directed bench for interconnect_top: a memory model fills an expected-read
// queue when each read burst is issued; beats are popped as rdata updates.
module tb_interconnect_top;
    import interconnect_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;

    interconnect_if bus_if ();

    interconnect_top u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus_if.io_start       = 1'b0;
        bus_if.io_top_wr      = 1'b0;
        bus_if.io_top_rd      = 1'b0;
        bus_if.io_top_address = '0;
        bus_if.io_top_length  = '0;
        bus_if.io_top_wdata   = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    endtask

    // Beat i carries base+i; busy_rd holds a competing read request on every later beat.
    task automatic write_burst(input logic st, input logic [3:0] a, input logic [3:0] l,
                               input logic [31:0] base, input logic also_rd,
                               input logic busy_rd);
        bus_if.io_start       = st;
        bus_if.io_top_wr      = 1'b1;
        bus_if.io_top_rd      = also_rd;
        bus_if.io_top_address = a;
        bus_if.io_top_length  = l;
        bus_if.io_top_wdata   = base;
        tick();
        if (st && (l != 4'd0)) begin
            for (int i = 0; i < int'(l); i++) model[4'(a + i)] = 32'(base + i);
        end
        bus_if.io_top_wr      = 1'b0;
        bus_if.io_top_rd      = busy_rd;
        bus_if.io_top_address = 4'(a + 8);
        bus_if.io_top_length  = 4'd1;
        for (int i = 1; i < int'(l); i++) begin
            bus_if.io_top_wdata = 32'(base + i);
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic read_burst(input logic [3:0] a, input logic [3:0] l, input string tag);
        logic [31:0] last;
        for (int i = 0; i < int'(l); i++) exp_q.push_back(model[4'(a + i)]);
        bus_if.io_start       = 1'b1;
        bus_if.io_top_rd      = 1'b1;
        bus_if.io_top_address = a;
        bus_if.io_top_length  = l;
        tick();
        idle_inputs();
        last = '0;
        for (int i = 0; i < int'(l); i++) begin
            tick();
            last = exp_q.pop_front();
            check($sformatf("%s[%0d]", tag, i), bus_if.io_top_rdata, last);
        end
        tick();
        check({tag, "_hold"}, bus_if.io_top_rdata, last);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        clear_model();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_rdata", bus_if.io_top_rdata, 32'h0);
        check("reset_mstate", 32'(u_dut.u_master.state_q), 32'(M_IDLE));
        reset = 1'b1;
        tick();
        read_burst(4'd3, 4'd1, "rst_read");

        write_burst(1'b1, 4'd7, 4'd4, 32'hA, 1'b0, 1'b0);
        read_burst(4'd7, 4'd4, "burst");

        write_burst(1'b1, 4'd14, 4'd3, 32'h1, 1'b0, 1'b0);
        read_burst(4'd14, 4'd3, "wrap");

        write_burst(1'b0, 4'd5, 4'd1, 32'h55, 1'b0, 1'b0);
        read_burst(4'd5, 4'd1, "ign_start");
        write_burst(1'b1, 4'd5, 4'd0, 32'h55, 1'b0, 1'b0);
        read_burst(4'd5, 4'd1, "ign_len");

        write_burst(1'b1, 4'd10, 4'd4, 32'h100, 1'b0, 1'b1);
        read_burst(4'd10, 4'd4, "busy");

        write_burst(1'b1, 4'd12, 4'd2, 32'h200, 1'b1, 1'b0);
        read_burst(4'd12, 4'd2, "prio");

        // Reset lands while beat 2 of a 4-beat write is on the request bus.
        bus_if.io_start       = 1'b1;
        bus_if.io_top_wr      = 1'b1;
        bus_if.io_top_address = 4'd9;
        bus_if.io_top_length  = 4'd4;
        bus_if.io_top_wdata   = 32'h300;
        tick();
        bus_if.io_top_wr      = 1'b0;
        bus_if.io_top_wdata   = 32'h301;
        tick();
        bus_if.io_top_wdata   = 32'h302;
        tick();
        reset = 1'b0;
        #1;
        check("midrst_rdata", bus_if.io_top_rdata, 32'h0);
        check("midrst_mstate", 32'(u_dut.u_master.state_q), 32'(M_IDLE));
        check("midrst_valid", 32'(u_dut.u_master.req_q.valid), 32'h0);
        clear_model();
        idle_inputs();
        @(negedge clock);
        reset = 1'b1;
        tick();

        write_burst(1'b1, 4'd9, 4'd2, 32'h400, 1'b0, 1'b0);
        read_burst(4'd9, 4'd2, "post_rst");
        read_burst(4'd11, 4'd1, "post_rst_clr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
